// File: rtl/clock_edge_monitor.sv
// Receiver for a slow toggle clock: synchronises it into the system domain,
// regenerates per-edge pulses, measures the half-period and flags a stopped input.
module clock_edge_monitor #(
   parameter int W_COUNT     = 16,
   parameter int TIMEOUT     = 1000,
   parameter int SYNC_STAGES = 2
) (
   input  logic               i_clk,
   input  logic               i_reset_n,
   input  logic               i_gen_clk,
   output logic               o_roll_over,
   output logic               o_rise,
   output logic [W_COUNT-1:0] o_half_period,
   output logic               o_valid,
   output logic               o_stuck
);

   localparam int NS = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;
   localparam logic [W_COUNT-1:0] CNT_MAX   = '1;
   localparam logic [W_COUNT-1:0] CNT_ONE   = W_COUNT'(1);
   localparam logic [W_COUNT-1:0] TIMEOUT_C = W_COUNT'(TIMEOUT);

   typedef enum logic [1:0] {
      WAIT_FIRST,
      ARMED,
      MEASURING,
      STUCK
   } state_t;

   state_t             state;
   logic [NS-1:0]      sync_q;
   logic               gen_p;
   logic               gen_s;
   logic               edge_det;
   logic               rise_det;
   logic [W_COUNT-1:0] cnt;
   logic [W_COUNT-1:0] cnt_inc;
   logic               timeout_hit;

   function automatic logic [W_COUNT-1:0] sat_inc(input logic [W_COUNT-1:0] v);
      return (v == CNT_MAX) ? v : v + CNT_ONE;
   endfunction

   // synchroniser stages plus one history flop for edge detection
   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         sync_q <= '0;
         gen_p  <= 1'b0;
      end else begin
         sync_q <= {sync_q[NS-2:0], i_gen_clk};
         gen_p  <= sync_q[NS-1];
      end
   end

   assign gen_s    = sync_q[NS-1];
   assign edge_det = gen_s ^ gen_p;
   assign rise_det = gen_s & ~gen_p;
   assign cnt_inc  = sat_inc(cnt);

   // an edge in the same cycle as the timeout takes priority
   assign timeout_hit = (state != STUCK) && !edge_det && (cnt_inc >= TIMEOUT_C);

   always_ff @(posedge i_clk or negedge i_reset_n) begin
      if (!i_reset_n) begin
         state         <= WAIT_FIRST;
         cnt           <= '0;
         o_half_period <= '0;
         o_valid       <= 1'b0;
         o_stuck       <= 1'b0;
         o_roll_over   <= 1'b0;
         o_rise        <= 1'b0;
      end else begin
         o_roll_over <= edge_det;
         o_rise      <= rise_det;
         if (edge_det) begin
            cnt <= CNT_ONE;
            case (state)
               WAIT_FIRST: state <= ARMED;
               ARMED: begin
                  state         <= MEASURING;
                  o_half_period <= cnt;
                  o_valid       <= 1'b1;
               end
               MEASURING: o_half_period <= cnt;
               STUCK: begin
                  state   <= ARMED;
                  o_stuck <= 1'b0;
               end
               default: state <= WAIT_FIRST;
            endcase
         end else begin
            cnt <= cnt_inc;
            if (timeout_hit) begin
               state   <= STUCK;
               o_stuck <= 1'b1;
               o_valid <= 1'b0;
            end
         end
      end
   end

endmodule

// File: tb/tb_clock_edge_monitor.sv
// Directed bench for clock_edge_monitor: vector table for the main timeline,
// hand sequences for async reset, never-started generator and narrow counter.
module tb_clock_edge_monitor;

   logic        clk = 1'b0;
   logic        rst_n = 1'b1;
   logic        gen_a = 1'b0;
   logic        gen_b = 1'b0;

   logic        roll_a, rise_a, valid_a, stuck_a;
   logic [15:0] half_a;
   logic        roll_b, rise_b, valid_b, stuck_b;
   logic [3:0]  half_b;

   int checks = 0;
   int errors = 0;

   clock_edge_monitor #(.W_COUNT(16), .TIMEOUT(20), .SYNC_STAGES(2)) dut_a (
      .i_clk(clk), .i_reset_n(rst_n), .i_gen_clk(gen_a),
      .o_roll_over(roll_a), .o_rise(rise_a), .o_half_period(half_a),
      .o_valid(valid_a), .o_stuck(stuck_a)
   );

   clock_edge_monitor #(.W_COUNT(4), .TIMEOUT(15), .SYNC_STAGES(2)) dut_b (
      .i_clk(clk), .i_reset_n(rst_n), .i_gen_clk(gen_b),
      .o_roll_over(roll_b), .o_rise(rise_b), .o_half_period(half_b),
      .o_valid(valid_b), .o_stuck(stuck_b)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic        rst_n;
      logic        gen;
      int          adv;
      logic        roll;
      logic        rise;
      logic [15:0] half;
      logic        valid;
      logic        stuck;
   } vec_t;

   vec_t vecs[$];

   function automatic vec_t mk(input logic r, input logic g, input int a, input logic ro,
                               input logic ri, input logic [15:0] h, input logic v,
                               input logic s);
      vec_t t;
      t.rst_n = r; t.gen = g; t.adv = a; t.roll = ro; t.rise = ri;
      t.half = h; t.valid = v; t.stuck = s;
      return t;
   endfunction

   task automatic chk(input string nm, input logic [15:0] act, input logic [15:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0d required=%0d", nm, act, exp);
      end
   endtask

   task automatic chk_a(input string tag, input logic ro, input logic ri,
                        input logic [15:0] h, input logic v, input logic s);
      chk({tag, "_roll"},  {15'd0, roll_a},  {15'd0, ro});
      chk({tag, "_rise"},  {15'd0, rise_a},  {15'd0, ri});
      chk({tag, "_half"},  half_a,           h);
      chk({tag, "_valid"}, {15'd0, valid_a}, {15'd0, v});
      chk({tag, "_stuck"}, {15'd0, stuck_a}, {15'd0, s});
   endtask

   task automatic chk_b(input string tag, input logic ro, input logic ri,
                        input logic [15:0] h, input logic v, input logic s);
      chk({tag, "_roll"},  {15'd0, roll_b},  {15'd0, ro});
      chk({tag, "_rise"},  {15'd0, rise_b},  {15'd0, ri});
      chk({tag, "_half"},  {12'd0, half_b},  h);
      chk({tag, "_valid"}, {15'd0, valid_b}, {15'd0, v});
      chk({tag, "_stuck"}, {15'd0, stuck_b}, {15'd0, s});
   endtask

   task automatic step(input int n);
      repeat (n) @(negedge clk);
   endtask

   initial begin
      // rst, gen, adv, roll, rise, half, valid, stuck  (negedge index after release)
      vecs.push_back(mk(0, 0, 2,  0, 0, 0,  0, 0));
      vecs.push_back(mk(1, 0, 1,  0, 0, 0,  0, 0));  // 1
      vecs.push_back(mk(1, 1, 3,  1, 1, 0,  0, 0));  // 4  first edge, no measurement
      vecs.push_back(mk(1, 1, 1,  0, 0, 0,  0, 0));  // 5
      vecs.push_back(mk(1, 1, 6,  0, 0, 0,  0, 0));  // 11
      vecs.push_back(mk(1, 0, 3,  1, 0, 10, 1, 0));  // 14 second edge -> valid
      vecs.push_back(mk(1, 0, 1,  0, 0, 10, 1, 0));  // 15
      vecs.push_back(mk(1, 0, 6,  0, 0, 10, 1, 0));  // 21
      vecs.push_back(mk(1, 1, 3,  1, 1, 10, 1, 0));  // 24
      vecs.push_back(mk(1, 1, 1,  0, 0, 10, 1, 0));  // 25
      vecs.push_back(mk(1, 1, 6,  0, 0, 10, 1, 0));  // 31
      vecs.push_back(mk(1, 0, 3,  1, 0, 10, 1, 0));  // 34
      vecs.push_back(mk(1, 0, 1,  0, 0, 10, 1, 0));  // 35
      vecs.push_back(mk(1, 0, 3,  0, 0, 10, 1, 0));  // 38
      vecs.push_back(mk(1, 1, 3,  1, 1, 7,  1, 0));  // 41 first 7-cycle interval
      vecs.push_back(mk(1, 1, 1,  0, 0, 7,  1, 0));  // 42
      vecs.push_back(mk(1, 1, 3,  0, 0, 7,  1, 0));  // 45
      vecs.push_back(mk(1, 0, 3,  1, 0, 7,  1, 0));  // 48 last edge before hold
      vecs.push_back(mk(1, 0, 1,  0, 0, 7,  1, 0));  // 49
      vecs.push_back(mk(1, 0, 17, 0, 0, 7,  1, 0));  // 66 one cycle short of timeout
      vecs.push_back(mk(1, 0, 1,  0, 0, 7,  0, 1));  // 67 stuck, half retained
      vecs.push_back(mk(1, 0, 5,  0, 0, 7,  0, 1));  // 72
      vecs.push_back(mk(1, 1, 3,  1, 1, 7,  0, 0));  // 75 stuck clears, armed
      vecs.push_back(mk(1, 1, 2,  0, 0, 7,  0, 0));  // 77
      vecs.push_back(mk(1, 0, 3,  1, 0, 5,  1, 0));  // 80 valid again
      vecs.push_back(mk(1, 0, 2,  0, 0, 5,  1, 0));  // 82
      vecs.push_back(mk(1, 1, 3,  1, 1, 5,  1, 0));  // 85
      vecs.push_back(mk(1, 1, 16, 0, 0, 5,  1, 0));  // 101
      vecs.push_back(mk(1, 0, 3,  1, 0, 19, 1, 0));  // 104 edge on timeout cycle
      vecs.push_back(mk(1, 0, 1,  0, 0, 19, 1, 0));  // 105

      #1;
      for (int i = 0; i < vecs.size(); i++) begin
         rst_n = vecs[i].rst_n;
         gen_a = vecs[i].gen;
         step(vecs[i].adv);
         chk_a($sformatf("v%0d", i), vecs[i].roll, vecs[i].rise, vecs[i].half,
               vecs[i].valid, vecs[i].stuck);
      end

      // async reset asserted between edges while a pulse is high
      gen_a = 1'b1;
      step(3);
      chk_a("pre_rst", 1, 1, 4, 1, 0);
      #2 rst_n = 1'b0;
      #1 chk_a("async_rst", 0, 0, 0, 0, 0);
      chk_b("async_rst_b", 0, 0, 0, 0, 0);
      step(2);
      rst_n = 1'b1;
      step(3);
      chk_a("post_rst_e1", 1, 1, 0, 0, 0);
      gen_a = 1'b0;
      step(3);
      chk_a("post_rst_e2", 1, 0, 3, 1, 0);

      // narrow counter, generator never started
      step(8);
      chk_b("b_idle14", 0, 0, 0, 0, 0);
      step(1);
      chk_b("b_idle15", 0, 0, 0, 0, 1);
      step(20);
      chk_b("b_idle35", 0, 0, 0, 0, 1);
      gen_b = 1'b1;
      step(3);
      chk_b("b_edge1", 1, 1, 0, 0, 0);
      step(13);
      chk_b("b_arm14", 0, 0, 0, 0, 0);
      step(1);
      chk_b("b_arm15", 0, 0, 0, 0, 1);
      step(3);
      gen_b = 1'b0;
      step(3);
      chk_b("b_edge2", 1, 0, 0, 0, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule

// File: doc/clock_edge_monitor.md
Name: clock_edge_monitor

Overview:
- Receiver-side counterpart to the team's rollover-driven toggle clock generator: takes that slow, generated clock as an asynchronous input into a fast system clock domain.
- Synchronises the input and regenerates single-cycle rollover pulses, one per toggle of the input.
- Measures the half-period in system cycles and flags a stuck (stopped) input clock.
- Used by downstream logic and testbenches to check divider output and to re-derive tick events.

Parameters:
- W_COUNT, 16, width of the half-period counter and the measurement output.
- TIMEOUT, 1000, system cycles without an input edge before the stuck flag is raised; must satisfy 1 <= TIMEOUT < 2**W_COUNT.
- SYNC_STAGES, 2, number of synchroniser flip-flops on i_gen_clk; minimum 2.

Ports:
- i_clk  input  1  system clock; all state updates on posedge.
- i_reset_n  input  1  reset, asynchronous and active-low.
- i_gen_clk  input  1  monitored generated clock; asynchronous to i_clk.
- o_roll_over  output  1  one-cycle pulse per detected edge (rising or falling) of i_gen_clk.
- o_rise  output  1  one-cycle pulse, rising edges only.
- o_half_period  output  W_COUNT  system cycles between the last two detected edges; held until the next edge.
- o_valid  output  1  high once at least two edges are seen since reset or stuck recovery, so o_half_period is meaningful.
- o_stuck  output  1  high while no edge is seen for TIMEOUT cycles.

Behaviour:
- Reset (i_reset_n low, asynchronous): clear all synchroniser stages, the edge-history flop, counter, o_half_period, o_valid and o_stuck; state = WAIT_FIRST.
- o_roll_over and o_rise are low during reset and in the first cycle after reset release.
- Synchroniser: i_gen_clk passes through SYNC_STAGES flops. s = last stage; p = s delayed one cycle.
- Edge detection:
  - edge = s XOR p; rise = s AND NOT p.
  - o_roll_over = edge and o_rise = rise, both registered.
  - Latency from an i_gen_clk transition to the pulse: SYNC_STAGES+1 cycles (3 at default).
- Counter cnt:
  - Increments each cycle and saturates at 2**W_COUNT-1 (no wrap).
  - On an edge cycle cnt loads 1, so the edge cycle itself counts as the first cycle of the new interval.
- States:
  - WAIT_FIRST: on edge -> ARMED, cnt := 1; o_half_period unchanged.
  - ARMED: on edge -> MEASURING, o_half_period := cnt, o_valid := 1.
  - MEASURING: on each edge, o_half_period := cnt (registered, same cycle as the o_roll_over pulse).
  - Any state: when cnt reaches TIMEOUT with no edge -> STUCK; o_stuck := 1 and o_valid := 0; o_half_period keeps its last value.
  - STUCK: o_stuck stays high. On edge -> ARMED, o_stuck := 0, cnt := 1.
- Stuck counting in WAIT_FIRST: counting starts at reset release, so a generator that never starts raises o_stuck after TIMEOUT cycles.
- Simultaneous edge and timeout in the same cycle: the edge wins; no stuck is raised.
- Saturation: if TIMEOUT is near 2**W_COUNT, cnt saturates and never wraps. o_half_period reports the saturated value.
- Reset mid-measurement: all outputs clear asynchronously. The first post-reset edge is not measured.
- Glitches: an input pulse narrower than one i_clk period may be missed. This is acceptable; there is no requirement to detect it.

Test Plan:
- Reset, then toggle i_gen_clk every 10 i_clk cycles:
  - First pulse arrives 3 cycles after the first toggle.
  - o_valid rises at the second edge with o_half_period = 10.
  - Every edge gives exactly one o_roll_over; o_rise appears on alternating edges.
- Change the toggle interval from 10 to 7 cycles mid-run -> o_half_period updates to 7 at the first 7-cycle interval; no missed or extra pulses.
- TIMEOUT=20; hold i_gen_clk constant after running -> o_stuck = 1 and o_valid = 0 exactly 20 cycles after the last edge; o_half_period is retained.
  - Resume toggling every 5 cycles -> o_stuck clears on the first edge; o_valid returns on the second edge with o_half_period = 5.
- Assert i_reset_n low for 2 cycles asynchronously (mid-cycle) during running -> all outputs are 0 immediately; after release, the first edge does not set o_valid.
- W_COUNT=4, TIMEOUT=15, toggle every 20 cycles -> o_stuck rises; on the next edge o_stuck clears and the state goes to ARMED. No wrap-induced false measurements occur.
- Drive an edge in the exact cycle cnt would reach TIMEOUT -> o_stuck stays 0 and o_half_period = TIMEOUT-1.
